// File: rtl/mem_responder.sv
// Backing-memory responder for the L2 fill/writeback interface: an in-order
// request queue that holds every entry for a fixed latency, served from a local line array.
module mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 512,
  parameter int ID_W      = 4,
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 8,
  parameter int MEM_LINES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  input  logic [ID_W-1:0]   req_id,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_is_write,
  output logic [ID_W-1:0]   rsp_id,
  output logic [LINE_W-1:0] rsp_data,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int AGE_W = $clog2(LATENCY + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [LINE_W-1:0] mem [MEM_LINES];

  logic [DEPTH-1:0]  q_vld;
  logic [DEPTH-1:0]  q_wr;
  logic [AGE_W-1:0]  q_age  [DEPTH];
  logic [IDX_W-1:0]  q_idx  [DEPTH];
  logic [LINE_W-1:0] q_data [DEPTH];
  logic [ID_W-1:0]   q_id   [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              ready_en;
  logic              full;
  logic              enq;
  logic              deq;
  logic              head_wr;
  logic [IDX_W-1:0]  req_idx;
  logic              unused_addr_bits;

  function automatic logic [AGE_W-1:0] sat_age(input logic [AGE_W-1:0] age);
    return (age >= AGE_MAX) ? AGE_MAX : age + AGE_W'(1);
  endfunction

  assign req_idx          = req_addr[6 +: IDX_W];
  assign unused_addr_bits = ^{req_addr[5:0], req_addr[ADDR_W-1:6+IDX_W]};

  // Age saturates at LATENCY, i.e. it reached LATENCY-1 before the previous edge.
  assign full      = (count == CNT_FULL);
  assign req_ready = ready_en && !full;
  assign enq       = req_valid && req_ready;
  assign rsp_valid = q_vld[head] && (q_age[head] == AGE_MAX);
  assign deq       = rsp_valid && rsp_ready;
  assign head_wr   = q_wr[head];
  assign busy      = (count != '0);

  assign rsp_is_write = rsp_valid && head_wr;
  assign rsp_id       = rsp_valid ? q_id[head] : '0;
  assign rsp_data     = (rsp_valid && !head_wr) ? mem[q_idx[head]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      q_vld    <= '0;
      for (int i = 0; i < DEPTH; i++) q_age[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && (tail == PTR_W'(i))) begin
          q_vld[i] <= 1'b1;
          q_age[i] <= '0;
        end else begin
          if (deq && (head == PTR_W'(i))) q_vld[i] <= 1'b0;
          if (q_vld[i]) q_age[i] <= sat_age(q_age[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_wr[tail]   <= req_is_write;
      q_idx[tail]  <= req_idx;
      q_data[tail] <= req_data;
      q_id[tail]   <= req_id;
    end
  end

  // Writes land in the array as they retire, so younger reads see them.
  always_ff @(posedge clk) begin
    if (deq && head_wr) mem[q_idx[head]] <= q_data[head];
  end

`ifdef ASSERT
  a_no_enq_full: assert property (@(posedge clk) disable iff (!reset) !(enq && full));
  a_stall_stable: assert property (@(posedge clk) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) &&
                                   $stable(rsp_is_write) && $stable(rsp_data)));
  a_rst_no_rsp: assert property (@(posedge clk) !reset |-> !rsp_valid);
`endif

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Backing-memory responder at the far end of the L2 fill/writeback request interface. It plays the memory side of the `t_mem_req_pkt` / `t_mem_rsp_pkt` protocol, below l2.
- Accepts line-granular read and write requests into an in-order queue and holds each for a fixed latency.
- Services requests from its own line array and returns responses under valid/ready backpressure.
- Used under l2 in full-core simulation, and standalone to exercise l2 miss paths.

Parameters:
- ADDR_W, 32: request byte-address width.
- LINE_W, 512: cache-line data width (64B line, 6 offset bits).
- ID_W, 4: request tag width, echoed in the response.
- DEPTH, 4: request queue entries; power of 2, ≥2.
- LATENCY, 8: minimum cycles from request acceptance to first response-valid; ≥1.
- MEM_LINES, 1024: lines of backing storage; power of 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_is_write  in  1  1 = line write, 0 = line read.
- req_addr  in  ADDR_W  byte address; bits [5:0] ignored.
- req_data  in  LINE_W  write data; ignored for reads.
- req_id  in  ID_W  request tag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_is_write  out  1  echoes the request's req_is_write.
- rsp_id  out  ID_W  echoes the request's req_id.
- rsp_data  out  LINE_W  read data; 0 for write acks.
- busy  out  1  queue non-empty.

Behaviour:
- Reset (reset==0, async):
  - Queue empty; head/tail pointers and count cleared; all age counters cleared.
  - Outputs: req_ready=0 while asserted, then 1 from the first cycle after deassertion; rsp_valid=0, rsp_is_write=0, rsp_id=0, rsp_data=0, busy=0.
  - Line array is not reset; the testbench preloads it by backdoor.
  - Reset mid-operation drops all queued requests; no response is produced for them.
- Accept:
  - req_ready = !full, registered-equivalent. Not combinational on rsp_ready: a full queue deasserts req_ready even if a dequeue occurs the same cycle.
  - Handshake = req_valid && req_ready at the clock edge. Entry written at tail with {is_write, line index, data, id}; age=0.
- Line index = req_addr[6 +: log2(MEM_LINES)]. Upper address bits are ignored, so addresses alias modulo MEM_LINES lines.
- Aging:
  - Each valid entry's age increments every cycle, saturating at LATENCY.
  - Head is eligible when age ≥ LATENCY-1 at the prior edge. A request accepted at edge T can therefore show rsp_valid no earlier than cycle T+LATENCY.
- Response:
  - rsp_valid = head valid && eligible. Fields come from the head entry.
  - Read: rsp_data = array[head index], combinational read.
  - Write: rsp_data = 0.
  - rsp_* remain stable while rsp_valid && !rsp_ready.
- Dequeue on rsp_valid && rsp_ready: head pointer advances and count decrements.
  - If the head is a write, array[index] <= data at that same edge.
  - A younger read to the same line therefore returns the new data.
- Ordering: strictly in order; no bypass or reordering across ids. Duplicate ids are legal.
- Simultaneous enqueue and dequeue (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full is when count==DEPTH; empty is when count==0.
- Back-to-back: once the head drains, the next entry responds immediately if it has already aged (sustained 1 response/cycle), otherwise when its own age becomes eligible.
- busy = count != 0.
- Assertions (under ASSERT):
  - no enqueue when full;
  - rsp fields stable under stall;
  - reset==0 forces rsp_valid==0.

Test Plan:
- Read latency: preload line 5 = 0xA5 pattern; LATENCY=8; read addr 0x140, id 3 accepted at cycle 10, rsp_ready=1 → rsp_valid first at cycle 18 with id=3, data=pattern, rsp_is_write=0.
- Write-then-read: write addr 0x80 data 0x1234 id 1, then read addr 0x80 id 2 on the next cycle → write ack id 1 (data 0), then read id 2 returns 0x1234.
- Full/backpressure: rsp_ready=0; 4 reads accepted, req_ready drops after the 4th; a 5th request is held. Raise rsp_ready at cycle 30 → 4 responses on cycles 30–33 in order; req_ready rises and the 5th request is accepted.
- Stall stability: rsp_ready toggles 0/1 every cycle → each response is held unchanged until handshake; no duplicates or losses.
- Aliasing: read addr 0x140 + MEM_LINES*64 → returns line 5 data.
- Reset mid-flight: 3 reads queued; assert reset for 2 cycles → rsp_valid=0, busy=0; no responses after release; a new request then completes in LATENCY cycles.
